// File: rtl/slave_split_ctrl_if.sv
// Bus-side signal bundle between a split-capable slave port and its split controller.
interface slave_split_ctrl_if;
   logic slv_sel;
   logic txn_start;
   logic tx_done;
   logic mem_ready;
   logic mem_req;
   logic SPLIT_EN;
   logic port_hold;
   logic resume;
   logic txn_err;
   logic busy;

   modport slave (
      input  slv_sel, txn_start, tx_done, mem_ready,
      output mem_req, SPLIT_EN, port_hold, resume, txn_err, busy
   );

   modport master (
      output slv_sel, txn_start, tx_done, mem_ready,
      input  mem_req, SPLIT_EN, port_hold, resume, txn_err, busy
   );
endinterface

// File: rtl/slave_split_ctrl.sv
// Slave-side split controller: requests a bus split while slow memory is pending,
// resumes the transfer once re-granted, or aborts after MAX_WAIT cycles.
module slave_split_ctrl #(
   parameter int unsigned SPLIT_THRESH = 4,
   parameter int unsigned MAX_WAIT     = 200,
   parameter int unsigned CNT_W        = 8
) (
   input  logic              MASTER_CLK,
   input  logic              MASTER_RST,
   slave_split_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_MEM,
      SPLIT,
      REGRANT,
      ACTIVE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               mem_req_q, mem_req_d;
   logic               split_en_q, split_en_d;
   logic               port_hold_q, port_hold_d;
   logic               resume_q, resume_d;
   logic               txn_err_q, txn_err_d;
   logic               busy_q, busy_d;

   // cnt holds edges-since-entry minus one, so thresholds compare against N-1
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge MASTER_CLK or posedge MASTER_RST) begin
      if (MASTER_RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         split_en_q  <= 1'b0;
         port_hold_q <= 1'b0;
         resume_q    <= 1'b0;
         txn_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         split_en_q  <= split_en_d;
         port_hold_q <= port_hold_d;
         resume_q    <= resume_d;
         txn_err_q   <= txn_err_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      split_en_d  = split_en_q;
      port_hold_d = port_hold_q;
      resume_d    = 1'b0;
      txn_err_d   = 1'b0;
      busy_d      = busy_q;

      unique case (state_q)
         IDLE: begin
            if (bus.txn_start && bus.slv_sel) begin
               state_d     = WAIT_MEM;
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               port_hold_d = 1'b1;
               busy_d      = 1'b1;
            end
         end
         WAIT_MEM: begin
            cnt_d = cnt_inc;
            if (bus.mem_ready) begin
               state_d     = ACTIVE;
               mem_req_d   = 1'b0;
               port_hold_d = 1'b0;
            end else if (cnt_q == CNT_W'(SPLIT_THRESH - 1)) begin
               state_d    = SPLIT;
               split_en_d = 1'b1;
            end
         end
         SPLIT: begin
            cnt_d = cnt_inc;
            if (bus.mem_ready) begin
               state_d    = REGRANT;
               mem_req_d  = 1'b0;
               split_en_d = 1'b0;
            end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
               state_d     = IDLE;
               split_en_d  = 1'b0;
               mem_req_d   = 1'b0;
               port_hold_d = 1'b0;
               busy_d      = 1'b0;
               txn_err_d   = 1'b1;
            end
         end
         REGRANT: begin
            // no timeout here: the other master's split transfer may take arbitrarily long
            if (bus.slv_sel) begin
               state_d     = ACTIVE;
               port_hold_d = 1'b0;
               resume_d    = 1'b1;
            end
         end
         ACTIVE: begin
            if (bus.tx_done) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.SPLIT_EN  = split_en_q;
   assign bus.port_hold = port_hold_q;
   assign bus.resume    = resume_q;
   assign bus.txn_err   = txn_err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_slave_split_ctrl.sv
// Directed bench for slave_split_ctrl: timeline model checked every cycle plus literal spot checks.
module tb_slave_split_ctrl;
   localparam int unsigned THR  = 4;
   localparam int unsigned MAXW = 20;

   logic MASTER_CLK = 1'b0;
   logic MASTER_RST = 1'b1;
   int   total = 0;
   int   bad   = 0;

   slave_split_ctrl_if bus ();

   slave_split_ctrl #(.SPLIT_THRESH(THR), .MAX_WAIT(MAXW), .CNT_W(8)) dut (
      .MASTER_CLK (MASTER_CLK),
      .MASTER_RST (MASTER_RST),
      .bus        (bus.slave)
   );

   always #5 MASTER_CLK = ~MASTER_CLK;

   // Model: age = edges since the accepting edge; phases tracked as plain facts about the transaction
   typedef struct packed {
      logic txn;
      logic got;
      logic split;
      logic data;
      logic resume;
      logic err;
      int   age;
   } model_t;

   model_t m = '0;

   function automatic model_t model_next(model_t c, logic sel, logic start, logic done, logic rdy);
      model_t n = c;
      n.resume = 1'b0;
      n.err    = 1'b0;
      if (!c.txn) begin
         if (start && sel) begin
            n.txn = 1'b1; n.age = 0; n.got = 1'b0; n.split = 1'b0; n.data = 1'b0;
         end
      end else begin
         n.age = c.age + 1;
         if (!c.got) begin
            if (rdy) begin
               n.got  = 1'b1;
               n.data = !c.split;
            end else if (!c.split && n.age == int'(THR)) begin
               n.split = 1'b1;
            end else if (c.split && n.age == int'(MAXW)) begin
               n.err = 1'b1;
               n.txn = 1'b0;
            end
         end else if (!c.data) begin
            if (sel) begin
               n.data   = 1'b1;
               n.resume = 1'b1;
            end
         end else if (done) begin
            n.txn = 1'b0;
         end
      end
      return n;
   endfunction

   always @(posedge MASTER_CLK or posedge MASTER_RST) begin
      if (MASTER_RST) m <= '0;
      else m <= model_next(m, bus.slv_sel, bus.txn_start, bus.tx_done, bus.mem_ready);
   end

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge MASTER_CLK) begin
      chk("model_busy",      bus.busy,      m.txn);
      chk("model_mem_req",   bus.mem_req,   m.txn && !m.got);
      chk("model_split_en",  bus.SPLIT_EN,  m.txn && m.split && !m.got);
      chk("model_port_hold", bus.port_hold, m.txn && !m.data);
      chk("model_resume",    bus.resume,    m.resume);
      chk("model_txn_err",   bus.txn_err,   m.err);
   end

   task automatic step(input logic sel, input logic start, input logic done, input logic rdy);
      bus.slv_sel   = sel;
      bus.txn_start = start;
      bus.tx_done   = done;
      bus.mem_ready = rdy;
      @(posedge MASTER_CLK);
      #1;
   endtask

   initial begin
      bus.slv_sel = 1'b0; bus.txn_start = 1'b0; bus.tx_done = 1'b0; bus.mem_ready = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_split_en", bus.SPLIT_EN, 1'b0);
      chk("rst_port_hold", bus.port_hold, 1'b0);
      MASTER_RST = 1'b0;
      step(0, 0, 0, 0);

      // fast memory: ready at E2, done at E5
      step(1, 1, 0, 0);                       // E0
      chk("fast_hold_e0", bus.port_hold, 1'b1);
      chk("fast_busy_e0", bus.busy, 1'b1);
      step(1, 0, 0, 0);                       // E1
      chk("fast_hold_e1", bus.port_hold, 1'b1);
      step(1, 0, 0, 1);                       // E2
      chk("fast_hold_e2", bus.port_hold, 1'b0);
      step(1, 0, 0, 0);                       // E3
      step(1, 0, 0, 0);                       // E4
      chk("fast_no_split", bus.SPLIT_EN, 1'b0);
      step(1, 0, 1, 0);                       // E5
      chk("fast_busy_e5", bus.busy, 1'b0);

      // split and resume, with ignored starts in WAIT_MEM, SPLIT, ACTIVE
      step(1, 1, 0, 0);                       // E0
      step(1, 1, 0, 0);                       // E1 start ignored
      step(0, 0, 0, 0);                       // E2
      step(0, 0, 0, 0);                       // E3
      chk("split_not_yet", bus.SPLIT_EN, 1'b0);
      step(0, 0, 0, 0);                       // E4
      chk("split_rise_e4", bus.SPLIT_EN, 1'b1);
      step(1, 1, 0, 0);                       // E5 start ignored
      for (int i = 6; i <= 9; i++) step(0, 0, 0, 0);
      chk("split_held_e9", bus.SPLIT_EN, 1'b1);
      step(0, 0, 0, 1);                       // E10
      chk("split_fall_e10", bus.SPLIT_EN, 1'b0);
      chk("regrant_hold", bus.port_hold, 1'b1);
      for (int i = 11; i <= 13; i++) step(0, 0, 0, 0);
      chk("regrant_no_resume", bus.resume, 1'b0);
      step(1, 0, 0, 0);                       // E14
      chk("resume_e14", bus.resume, 1'b1);
      chk("resume_hold_fall", bus.port_hold, 1'b0);
      step(1, 1, 0, 0);                       // E15 start in ACTIVE ignored
      chk("resume_one_cycle", bus.resume, 1'b0);
      chk("active_busy", bus.busy, 1'b1);
      step(1, 0, 1, 0);
      chk("split_done_busy", bus.busy, 1'b0);

      // start without select is ignored
      step(0, 1, 0, 0);
      chk("nosel_busy", bus.busy, 1'b0);
      chk("nosel_mem_req", bus.mem_req, 1'b0);

      // timeout at E20, with an ignored start inside SPLIT
      step(1, 1, 0, 0);                       // E0
      for (int i = 1; i <= 19; i++) begin
         if (i == 10) step(1, 1, 0, 0);
         else step(0, 0, 0, 0);
      end
      chk("to_split_e19", bus.SPLIT_EN, 1'b1);
      chk("to_no_err_e19", bus.txn_err, 1'b0);
      step(0, 0, 0, 0);                       // E20
      chk("to_err_e20", bus.txn_err, 1'b1);
      chk("to_split_fall", bus.SPLIT_EN, 1'b0);
      chk("to_busy_fall", bus.busy, 1'b0);
      step(0, 0, 0, 0);
      chk("to_err_one_cycle", bus.txn_err, 1'b0);

      // tie: ready exactly at E4
      step(1, 1, 0, 0);
      for (int i = 1; i <= 3; i++) step(0, 0, 0, 0);
      step(0, 0, 0, 1);                       // E4
      chk("tie4_no_split", bus.SPLIT_EN, 1'b0);
      chk("tie4_hold", bus.port_hold, 1'b0);
      step(0, 0, 1, 0);
      chk("tie4_done", bus.busy, 1'b0);

      // tie: ready exactly at E20
      step(1, 1, 0, 0);
      for (int i = 1; i <= 19; i++) step(0, 0, 0, 0);
      step(0, 0, 0, 1);                       // E20
      chk("tie20_no_err", bus.txn_err, 1'b0);
      chk("tie20_busy", bus.busy, 1'b1);
      chk("tie20_hold", bus.port_hold, 1'b1);
      step(1, 0, 0, 0);
      chk("tie20_resume", bus.resume, 1'b1);
      step(1, 0, 1, 0);
      chk("tie20_done", bus.busy, 1'b0);

      // asynchronous reset while in SPLIT
      step(1, 1, 0, 0);
      for (int i = 1; i <= 6; i++) step(0, 0, 0, 0);
      chk("ar_split_pre", bus.SPLIT_EN, 1'b1);
      #2 MASTER_RST = 1'b1;
      #1;
      chk("ar_split_en", bus.SPLIT_EN, 1'b0);
      chk("ar_mem_req", bus.mem_req, 1'b0);
      chk("ar_port_hold", bus.port_hold, 1'b0);
      chk("ar_busy", bus.busy, 1'b0);
      chk("ar_txn_err", bus.txn_err, 1'b0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      MASTER_RST = 1'b0;
      step(1, 1, 0, 0);
      chk("ar_restart_busy", bus.busy, 1'b1);
      step(1, 0, 0, 1);
      step(1, 0, 1, 0);
      chk("ar_restart_done", bus.busy, 1'b0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
